mlu_boot_loader: RTL and testbench
==================================

Name: mlu_boot_loader

Overview:
- Upstream feeder for the mlu_slice bootstrap port.
- Accepts a byte stream (4096 table bytes followed by one checksum byte) over a valid/ready handshake and writes each byte into the slice SRAMs with a timed N_WE strobe.
- Verifies the checksum, then releases N_BOOTED.
- One instance drives the shared bootstrap bus broadcast to every slice, since all slices hold the identical table.

Parameters:
- ADDR_WIDTH, 12, SRAM address width; the table holds 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 8, SRAM word and stream byte width.
- SETUP_CYCLES, 1, cycles that ADDR/DATA are stable with N_WE high before the strobe (legal range ≥1).
- WE_CYCLES, 1, width in cycles of the N_WE low pulse (legal range ≥1).

Ports:
- CLK  in  1  system clock.
- N_RST  in  1  asynchronous, active-low reset.
- IN_DATA  in  8  stream byte.
- IN_VALID  in  1  IN_DATA is valid.
- IN_READY  out  1  loader accepts a byte this cycle.
- BOOTSTRAP_ADDR  out  12  SRAM write address.
- BOOTSTRAP_DATA  out  8  SRAM write data.
- BOOTSTRAP_N_WE  out  1  active-low SRAM write strobe.
- N_BOOTED  out  1  high until the table is loaded and the checksum passes.
- BOOT_ERR  out  1  sticky checksum-failure flag.

Behaviour:
- Reset (async, while N_RST=0), all outputs forced immediately:
  - state=WAIT, ADDR=0, DATA=0, N_WE=1, N_BOOTED=1, BOOT_ERR=0, IN_READY=0, running sum=0.
  - Reset mid-write aborts the strobe at once; no partial pulse resumes.
- All outputs except IN_READY are registered. IN_READY is decoded from the state register only and never depends on IN_VALID.
- A transfer occurs when IN_VALID & IN_READY at a rising edge.
- States and transitions:
  - WAIT: IN_READY=1. On transfer: DATA<=IN_DATA, sum<=sum+IN_DATA (mod 256), go to SETUP. Otherwise stay.
  - SETUP: IN_READY=0, N_WE=1, held for SETUP_CYCLES cycles, then go to PULSE.
  - PULSE: N_WE=0 for exactly WE_CYCLES cycles, then go to HOLD. ADDR and DATA do not change while N_WE=0 or in the cycle after.
  - HOLD: N_WE=1 for one cycle. On exit ADDR<=ADDR+1, wrapping 0xFFF→0x000. If the old ADDR was 0xFFF go to CHECK, else go to WAIT.
  - CHECK: IN_READY=1. On transfer: if (sum+IN_DATA) mod 256 == 0 go to DONE, else go to FAIL. No SRAM write happens in CHECK.
  - DONE: N_BOOTED=0 (registered, so asserted the cycle after the checksum transfer). IN_READY=0. Terminal until reset.
  - FAIL: BOOT_ERR=1, N_BOOTED stays 1, IN_READY=0. Terminal until reset.
- Cost per table byte is 2+SETUP_CYCLES+WE_CYCLES cycles (4 with defaults) when IN_VALID is held high.
- With defaults and a continuous stream, N_BOOTED falls at cycle 4096*4+1 after the first transfer edge.
- IN_VALID deasserting in WAIT or CHECK stalls indefinitely. There is no timeout.
- IN_VALID and IN_DATA are ignored outside WAIT and CHECK. Extra bytes after DONE or FAIL are never accepted.
- Width rule: the sum is an 8-bit register; carries are discarded.
- Counters: the address counter is ADDR_WIDTH bits. The phase counter is wide enough for max(SETUP_CYCLES, WE_CYCLES).

Decomposition:
- Shared package common gains:
  - MLU_BOOT_ADDR_WIDTH=12 and MLU_BOOT_DATA_WIDTH=8.
  - The loader state enum mlu_boot_state_t {WAIT, SETUP, PULSE, HOLD, CHECK, DONE, FAIL}, so the top level and formal properties can reference it.
- No sub-module. The phase counter and address counter are inline. The module is self-contained in mlu_boot_loader.

Test Plan:
- Continuous stream, byte[i]=i[7:0] for i=0..4095, checksum 0x00 (sum of table is 0x00) → 4096 N_WE pulses, each 1 cycle wide. Pulse k has ADDR=k and DATA=k[7:0]. N_BOOTED falls 1 cycle after the checksum transfer. BOOT_ERR=0.
- Same table with checksum 0x01 → no write in CHECK. BOOT_ERR=1 and N_BOOTED=1 from the next cycle. IN_READY=0 thereafter. Extra valid bytes are not accepted.
- IN_VALID toggling 1/0 every cycle, all bytes 0xA5, checksum 0x00 (4096*0xA5 mod 256 = 0x00) → same write sequence with stalls only in WAIT. ADDR/DATA are never modified while N_WE=0. Boot completes with N_BOOTED=0.
- SETUP_CYCLES=3, WE_CYCLES=2, first byte 0x5A → ADDR=0 and DATA=0x5A stable for 3 cycles with N_WE high, then N_WE low for exactly 2 cycles, then 1 high cycle before IN_READY reasserts. Per-byte period is 7 cycles.
- Assert N_RST during PULSE of byte 100 → N_WE=1, ADDR=0, N_BOOTED=1 asynchronously. After release, a full fresh 4097-byte stream boots successfully from address 0.
- Boundary at byte 4095 → its write goes to ADDR=0xFFF. ADDR then wraps to 0x000 and the state enters CHECK with IN_READY=1. No write occurs to 0x000.

Source files
------------

// File: rtl/mlu_boot_loader_pkg.sv
// Shared bootstrap-bus widths and the loader state encoding.
// Kept in a package so the top level and any property files agree on the state names.
package mlu_boot_loader_pkg;

  localparam int MLU_BOOT_ADDR_WIDTH = 12;
  localparam int MLU_BOOT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    BOOT_WAIT,
    BOOT_SETUP,
    BOOT_PULSE,
    BOOT_HOLD,
    BOOT_CHECK,
    BOOT_DONE,
    BOOT_FAIL
  } mlu_boot_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mlu_boot_loader.sv
// Streams 2**ADDR_WIDTH table bytes into the slice SRAMs with a timed N_WE strobe, then
// verifies a trailing checksum byte and releases N_BOOTED or raises a sticky BOOT_ERR.
module mlu_boot_loader
  import mlu_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH   = MLU_BOOT_ADDR_WIDTH,
  parameter int DATA_WIDTH   = MLU_BOOT_DATA_WIDTH,
  parameter int SETUP_CYCLES = 1,
  parameter int WE_CYCLES    = 1
) (
  input  logic                  CLK,
  input  logic                  N_RST,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [ADDR_WIDTH-1:0] BOOTSTRAP_ADDR,
  output logic [DATA_WIDTH-1:0] BOOTSTRAP_DATA,
  output logic                  BOOTSTRAP_N_WE,
  output logic                  N_BOOTED,
  output logic                  BOOT_ERR
);

  localparam int PH_MAX = max_int(SETUP_CYCLES, WE_CYCLES);
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0]       SETUP_LAST = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0]       WE_LAST    = PH_W'(WE_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;

  mlu_boot_state_t       state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [PH_W-1:0]       ph_q, ph_d;
  logic                  n_we_q, n_we_d;
  logic                  n_booted_q, n_booted_d;
  logic                  boot_err_q, boot_err_d;
  logic [DATA_WIDTH-1:0] cks_sum;
  logic                  xfer;

  // Gated by N_RST so the port reads 0 while reset is held even though WAIT decodes as ready.
  assign IN_READY = N_RST & ((state_q == BOOT_WAIT) | (state_q == BOOT_CHECK));
  assign xfer     = IN_VALID & IN_READY;
  assign cks_sum  = sum_q + IN_DATA;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sum_d   = sum_q;
    ph_d    = ph_q;
    case (state_q)
      BOOT_WAIT: begin
        if (xfer) begin
          data_d  = IN_DATA;
          sum_d   = cks_sum;
          ph_d    = '0;
          state_d = BOOT_SETUP;
        end
      end
      BOOT_SETUP: begin
        if (ph_q == SETUP_LAST) begin
          ph_d    = '0;
          state_d = BOOT_PULSE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      BOOT_PULSE: begin
        if (ph_q == WE_LAST) begin
          ph_d    = '0;
          state_d = BOOT_HOLD;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      BOOT_HOLD: begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        state_d = (addr_q == ADDR_LAST) ? BOOT_CHECK : BOOT_WAIT;
      end
      BOOT_CHECK: begin
        if (xfer) begin
          state_d = (cks_sum == '0) ? BOOT_DONE : BOOT_FAIL;
        end
      end
      default: ;
    endcase
    // Outputs follow the next state so they change on the same edge as the state register.
    n_we_d     = (state_d != BOOT_PULSE);
    n_booted_d = (state_d != BOOT_DONE);
    boot_err_d = (state_d == BOOT_FAIL);
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q    <= BOOT_WAIT;
      addr_q     <= '0;
      data_q     <= '0;
      sum_q      <= '0;
      ph_q       <= '0;
      n_we_q     <= 1'b1;
      n_booted_q <= 1'b1;
      boot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      sum_q      <= sum_d;
      ph_q       <= ph_d;
      n_we_q     <= n_we_d;
      n_booted_q <= n_booted_d;
      boot_err_q <= boot_err_d;
    end
  end

  assign BOOTSTRAP_ADDR = addr_q;
  assign BOOTSTRAP_DATA = data_q;
  assign BOOTSTRAP_N_WE = n_we_q;
  assign N_BOOTED       = n_booted_q;
  assign BOOT_ERR       = boot_err_q;

endmodule

// File: tb/tb_mlu_boot_loader.sv
// Directed bench: default-timing loader for full boots, plus a SETUP=3/WE=2 instance for strobe timing.
module tb_mlu_boot_loader;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] addr;
  logic [7:0]  dat;
  logic        nwe, n_booted, boot_err;

  logic [7:0]  p_data = '0;
  logic        p_valid = 1'b0;
  logic        p_ready;
  logic [11:0] p_addr;
  logic [7:0]  p_dat;
  logic        p_nwe, p_n_booted, p_boot_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  mlu_boot_loader dut (
    .CLK(clk), .N_RST(n_rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .BOOTSTRAP_ADDR(addr), .BOOTSTRAP_DATA(dat), .BOOTSTRAP_N_WE(nwe),
    .N_BOOTED(n_booted), .BOOT_ERR(boot_err)
  );

  mlu_boot_loader #(.SETUP_CYCLES(3), .WE_CYCLES(2)) dut_p (
    .CLK(clk), .N_RST(n_rst), .IN_DATA(p_data), .IN_VALID(p_valid), .IN_READY(p_ready),
    .BOOTSTRAP_ADDR(p_addr), .BOOTSTRAP_DATA(p_dat), .BOOTSTRAP_N_WE(p_nwe),
    .N_BOOTED(p_n_booted), .BOOT_ERR(p_boot_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor for the default instance: pulse k must carry ADDR=k, DATA=exp_byte[k],
  // be one cycle wide, and ADDR/DATA must match the setup cycle before and the hold cycle after.
  logic [7:0]  exp_byte [0:4095];
  int          wr_cnt = 0;
  int          mon_err = 0;
  int          pulse_w = 0;
  logic        prev_low = 1'b0;
  logic [11:0] prev_addr = '0, pa = '0;
  logic [7:0]  prev_dat = '0, pd = '0;

  always @(negedge clk) begin
    if (!n_rst) begin
      wr_cnt   <= 0;
      mon_err  <= 0;
      pulse_w  <= 0;
      prev_low <= 1'b0;
    end else begin
      if (!nwe) begin
        if (!prev_low) begin
          pa      <= addr;
          pd      <= dat;
          pulse_w <= 1;
          if (addr !== prev_addr || dat !== prev_dat) mon_err <= mon_err + 1;
          if (addr !== wr_cnt[11:0] || dat !== exp_byte[wr_cnt[11:0]]) mon_err <= mon_err + 1;
        end else begin
          pulse_w <= pulse_w + 1;
          if (addr !== pa || dat !== pd) mon_err <= mon_err + 1;
        end
      end else if (prev_low) begin
        if (pulse_w != 1 || addr !== pa || dat !== pd) mon_err <= mon_err + 1;
        wr_cnt <= wr_cnt + 1;
      end
      prev_low <= !nwe;
    end
    prev_addr <= addr;
    prev_dat  <= dat;
  end

  int          first_edge, cks_edge, chk_wr;
  logic [11:0] chk_addr;
  logic        chk_ready_seen, nb_before;

  task automatic do_reset();
    in_valid = 1'b0;
    p_valid  = 1'b0;
    n_rst    = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  // Presents exp_byte[0..4095] then the checksum; stops after stop_at accepted bytes.
  task automatic drive_stream(input bit toggle, input logic [7:0] cks, input int stop_at);
    int idx = 0;
    int budget = 0;
    bit ph = 1'b0;
    chk_ready_seen = 1'b0;
    while (idx < stop_at) begin
      @(negedge clk);
      budget++;
      if (budget > 40000) begin
        total++; bad++;
        $display("FAIL stream_timeout accepted=%0d required=%0d", idx, stop_at);
        in_valid = 1'b0;
        return;
      end
      in_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      in_data = (idx < 4096) ? exp_byte[idx] : cks;
      if (idx == 4096 && in_ready && !chk_ready_seen) begin
        chk_ready_seen = 1'b1;
        chk_addr  = addr;
        chk_wr    = wr_cnt;
        nb_before = n_booted;
      end
      if (in_valid && in_ready) begin
        if (idx == 0) first_edge = cyc + 1;
        if (idx == 4096) cks_edge = cyc + 1;
        idx++;
      end
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    p_valid  = 1'b0;
    n_rst    = 1'b0;
    repeat (2) @(negedge clk);
    total += 6;
    if (nwe !== 1'b1)      begin bad++; $display("FAIL rst_nwe got=%b want=1", nwe); end
    if (addr !== 12'h000)  begin bad++; $display("FAIL rst_addr got=%h want=000", addr); end
    if (dat !== 8'h00)     begin bad++; $display("FAIL rst_data got=%h want=00", dat); end
    if (n_booted !== 1'b1) begin bad++; $display("FAIL rst_nbooted got=%b want=1", n_booted); end
    if (boot_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", boot_err); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", in_ready); end
    n_rst = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_continuous();
    for (int i = 0; i < 4096; i++) exp_byte[i] = 8'(i);
    do_reset();
    drive_stream(1'b0, 8'h00, 4097);
    @(negedge clk);
    in_valid = 1'b0;
    total += 10;
    if (nb_before !== 1'b1)  begin bad++; $display("FAIL cont_nbooted_before got=%b want=1", nb_before); end
    if (n_booted !== 1'b0)   begin bad++; $display("FAIL cont_nbooted got=%b want=0", n_booted); end
    if (boot_err !== 1'b0)   begin bad++; $display("FAIL cont_err got=%b want=0", boot_err); end
    if (in_ready !== 1'b0)   begin bad++; $display("FAIL cont_done_ready got=%b want=0", in_ready); end
    if (cks_edge - first_edge != 16384)
      begin bad++; $display("FAIL cont_latency got=%0d want=16384", cks_edge - first_edge); end
    if (chk_ready_seen !== 1'b1) begin bad++; $display("FAIL wrap_check_ready got=%b want=1", chk_ready_seen); end
    if (chk_addr !== 12'h000) begin bad++; $display("FAIL wrap_addr got=%h want=000", chk_addr); end
    if (chk_wr != 4096)      begin bad++; $display("FAIL wrap_writes got=%0d want=4096", chk_wr); end
    if (mon_err != 0)        begin bad++; $display("FAIL cont_write_seq got=%0d want=0", mon_err); end
    repeat (5) @(negedge clk);
    if (wr_cnt != 4096)      begin bad++; $display("FAIL cont_writes got=%0d want=4096", wr_cnt); end
  endtask

  task automatic test_bad_checksum();
    int ready_hits = 0;
    do_reset();
    drive_stream(1'b0, 8'h01, 4097);
    @(negedge clk);
    total += 3;
    if (boot_err !== 1'b1) begin bad++; $display("FAIL bad_err got=%b want=1", boot_err); end
    if (n_booted !== 1'b1) begin bad++; $display("FAIL bad_nbooted got=%b want=1", n_booted); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bad_ready got=%b want=0", in_ready); end
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (8) begin
      @(negedge clk);
      if (in_ready) ready_hits++;
    end
    in_valid = 1'b0;
    total += 4;
    if (ready_hits != 0)   begin bad++; $display("FAIL bad_extra_accept got=%0d want=0", ready_hits); end
    if (boot_err !== 1'b1) begin bad++; $display("FAIL bad_err_sticky got=%b want=1", boot_err); end
    if (wr_cnt != 4096)    begin bad++; $display("FAIL bad_writes got=%0d want=4096", wr_cnt); end
    if (mon_err != 0)      begin bad++; $display("FAIL bad_write_seq got=%0d want=0", mon_err); end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 4096; i++) exp_byte[i] = 8'hA5;
    do_reset();
    drive_stream(1'b1, 8'h00, 4097);
    @(negedge clk);
    in_valid = 1'b0;
    total += 4;
    if (n_booted !== 1'b0) begin bad++; $display("FAIL tog_nbooted got=%b want=0", n_booted); end
    if (boot_err !== 1'b0) begin bad++; $display("FAIL tog_err got=%b want=0", boot_err); end
    if (wr_cnt != 4096)    begin bad++; $display("FAIL tog_writes got=%0d want=4096", wr_cnt); end
    if (mon_err != 0)      begin bad++; $display("FAIL tog_write_seq got=%0d want=0", mon_err); end
  endtask

  task automatic test_timing();
    logic [6:0] nwe_pat = 7'b1100111;
    logic [6:0] rdy_pat = 7'b1000000;
    do_reset();
    @(negedge clk);
    p_valid = 1'b1;
    p_data  = 8'h5A;
    total++;
    if (p_ready !== 1'b1) begin bad++; $display("FAIL tim_ready0 got=%b want=1", p_ready); end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      p_data = 8'h11;
      total += 4;
      if (p_nwe !== nwe_pat[k])   begin bad++; $display("FAIL tim_nwe[%0d] got=%b want=%b", k, p_nwe, nwe_pat[k]); end
      if (p_ready !== rdy_pat[k]) begin bad++; $display("FAIL tim_ready[%0d] got=%b want=%b", k, p_ready, rdy_pat[k]); end
      if (p_dat !== 8'h5A)        begin bad++; $display("FAIL tim_data[%0d] got=%h want=5a", k, p_dat); end
      if (p_addr !== ((k < 6) ? 12'h000 : 12'h001))
        begin bad++; $display("FAIL tim_addr[%0d] got=%h", k, p_addr); end
    end
    @(negedge clk);
    p_valid = 1'b0;
    total += 2;
    if (p_dat !== 8'h11)  begin bad++; $display("FAIL tim_period_data got=%h want=11", p_dat); end
    if (p_ready !== 1'b0) begin bad++; $display("FAIL tim_period_ready got=%b want=0", p_ready); end
  endtask

  task automatic test_reset_midwrite();
    bit hit = 1'b0;
    for (int i = 0; i < 4096; i++) exp_byte[i] = 8'(i);
    do_reset();
    drive_stream(1'b0, 8'h00, 101);
    for (int n = 0; n < 10 && !hit; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (nwe === 1'b0) hit = 1'b1;
    end
    total += 2;
    if (!hit) begin bad++; $display("FAIL mid_pulse_seen got=0 want=1"); end
    if (addr !== 12'd100) begin bad++; $display("FAIL mid_pulse_addr got=%h want=064", addr); end
    #2 n_rst = 1'b0;
    #1;
    total += 5;
    if (nwe !== 1'b1)      begin bad++; $display("FAIL mid_rst_nwe got=%b want=1", nwe); end
    if (addr !== 12'h000)  begin bad++; $display("FAIL mid_rst_addr got=%h want=000", addr); end
    if (dat !== 8'h00)     begin bad++; $display("FAIL mid_rst_data got=%h want=00", dat); end
    if (n_booted !== 1'b1) begin bad++; $display("FAIL mid_rst_nbooted got=%b want=1", n_booted); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", in_ready); end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    drive_stream(1'b0, 8'h00, 4097);
    @(negedge clk);
    in_valid = 1'b0;
    total += 4;
    if (n_booted !== 1'b0) begin bad++; $display("FAIL fresh_nbooted got=%b want=0", n_booted); end
    if (boot_err !== 1'b0) begin bad++; $display("FAIL fresh_err got=%b want=0", boot_err); end
    if (wr_cnt != 4096)    begin bad++; $display("FAIL fresh_writes got=%0d want=4096", wr_cnt); end
    if (mon_err != 0)      begin bad++; $display("FAIL fresh_write_seq got=%0d want=0", mon_err); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_continuous();
    test_bad_checksum();
    test_toggle();
    test_reset_midwrite();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
